// File: rtl/uart_mem_cmd_initiator.sv
// Debug memory-access initiator: parses UART command frames, issues one memory
// request, serialises the reply. Optional macro UART_MEM_FRAME_TIMEOUT_EN adds an inter-byte gap timer.
module uart_mem_cmd_initiator #(
    parameter int RESP_TIMEOUT = 16,
    parameter int FRAME_GAP    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        cpu_enable,
    output logic        mem_req,
    output logic        mem_type,
    output logic [8:0]  mem_addr,
    output logic        mem_rw,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [41:0] mem_resp_data,
    output logic        busy
);

    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RESP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

    localparam logic [7:0] REPLY_ACK     = 8'hA5;
    localparam logic [7:0] REPLY_BUSY    = 8'hEB;
    localparam logic [7:0] REPLY_TIMEOUT = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ISSUE,
        S_WAIT,
        S_TX
    } state_t;

    state_t           state_reg, state_next;
    logic             type_reg, type_next;
    logic             rw_reg, rw_next;
    logic [8:0]       addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic [1:0]       data_cnt_reg, data_cnt_next;
    logic             req_reg, req_next;
    logic [CNT_W-1:0] resp_cnt_reg, resp_cnt_next;
    logic [47:0]      reply_reg, reply_next;
    logic [2:0]       tx_left_reg, tx_left_next;
    logic             tx_valid_reg, tx_valid_next;
    logic             gap_expired;
    logic             in_frame;

    assign in_frame = (state_reg == S_ADDR) || (state_reg == S_DATA);

`ifdef UART_MEM_FRAME_TIMEOUT_EN
    localparam int GAP_W = $clog2(FRAME_GAP + 1);

    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;

    assign gap_expired = in_frame && !rx_valid && (gap_cnt_reg == GAP_W'(FRAME_GAP - 1));

    always_comb begin
        gap_cnt_next = '0;
        if (in_frame && !rx_valid && !gap_expired)
            gap_cnt_next = gap_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            gap_cnt_reg <= '0;
        else
            gap_cnt_reg <= gap_cnt_next;
    end
`else
    // Without the gap timer a partial frame simply waits; FRAME_GAP is kept
    // referenced so both builds share one parameter list.
    assign gap_expired = in_frame & 1'b0 & (FRAME_GAP != 0);
`endif

    always_comb begin
        state_next    = state_reg;
        type_next     = type_reg;
        rw_next       = rw_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        data_cnt_next = data_cnt_reg;
        req_next      = req_reg;
        resp_cnt_next = resp_cnt_reg;
        reply_next    = reply_reg;
        tx_left_next  = tx_left_reg;
        tx_valid_next = tx_valid_reg;

        case (state_reg)
            S_IDLE: begin
                if (rx_valid) begin
                    rw_next    = rx_byte[7];
                    type_next  = rx_byte[6];
                    addr_next  = {rx_byte[0], 8'h00};
                    state_next = S_ADDR;
                end
            end

            S_ADDR: begin
                if (gap_expired) begin
                    state_next = S_IDLE;
                end else if (rx_valid) begin
                    addr_next[7:0] = rx_byte;
                    data_cnt_next  = 2'd0;
                    if (rw_reg) begin
                        state_next = S_DATA;
                    end else begin
                        // The request goes out on ISSUE entry unless the CPU owns the memories.
                        req_next      = !cpu_enable;
                        resp_cnt_next = '0;
                        state_next    = S_ISSUE;
                    end
                end
            end

            S_DATA: begin
                if (gap_expired) begin
                    state_next = S_IDLE;
                end else if (rx_valid) begin
                    wdata_next    = {wdata_reg[23:0], rx_byte};
                    data_cnt_next = data_cnt_reg + 2'd1;
                    if (data_cnt_reg == 2'd3) begin
                        req_next      = !cpu_enable;
                        resp_cnt_next = '0;
                        state_next    = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (resp_cnt_reg != CNT_MAX)
                    resp_cnt_next = resp_cnt_reg + 1'b1;
                if (!req_reg) begin
                    reply_next    = {REPLY_BUSY, 40'h0};
                    tx_left_next  = 3'd1;
                    tx_valid_next = 1'b1;
                    state_next    = S_TX;
                end else if (rw_reg) begin
                    req_next      = 1'b0;
                    reply_next    = {REPLY_ACK, 40'h0};
                    tx_left_next  = 3'd1;
                    tx_valid_next = 1'b1;
                    state_next    = S_TX;
                end else begin
                    state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                // A response on the final counted cycle still wins over the timeout.
                if (mem_resp_valid) begin
                    req_next      = 1'b0;
                    reply_next    = {6'b0, mem_resp_data};
                    tx_left_next  = 3'd6;
                    tx_valid_next = 1'b1;
                    state_next    = S_TX;
                end else if (resp_cnt_reg >= CNT_LAST) begin
                    req_next      = 1'b0;
                    reply_next    = {REPLY_TIMEOUT, 40'h0};
                    tx_left_next  = 3'd1;
                    tx_valid_next = 1'b1;
                    state_next    = S_TX;
                end else if (resp_cnt_reg != CNT_MAX) begin
                    resp_cnt_next = resp_cnt_reg + 1'b1;
                end
            end

            S_TX: begin
                if (tx_ready) begin
                    reply_next   = {reply_reg[39:0], 8'h00};
                    tx_left_next = tx_left_reg - 3'd1;
                    if (tx_left_reg == 3'd1) begin
                        tx_valid_next = 1'b0;
                        state_next    = S_IDLE;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            type_reg     <= 1'b0;
            rw_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            data_cnt_reg <= '0;
            req_reg      <= 1'b0;
            resp_cnt_reg <= '0;
            reply_reg    <= '0;
            tx_left_reg  <= '0;
            tx_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            type_reg     <= type_next;
            rw_reg       <= rw_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            data_cnt_reg <= data_cnt_next;
            req_reg      <= req_next;
            resp_cnt_reg <= resp_cnt_next;
            reply_reg    <= reply_next;
            tx_left_reg  <= tx_left_next;
            tx_valid_reg <= tx_valid_next;
        end
    end

    // The reply shifts out MSB byte first, so the head byte is always the top of the register.
    assign tx_byte   = reply_reg[47:40];
    assign tx_valid  = tx_valid_reg;
    assign mem_req   = req_reg;
    assign mem_type  = type_reg;
    assign mem_addr  = addr_reg;
    assign mem_rw    = rw_reg;
    assign mem_wdata = wdata_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_mem_cmd_initiator.sv
// Scoreboard bench for uart_mem_cmd_initiator: expected requests and reply
// bytes are queued when stimulus is driven and popped by negedge monitors.
module tb_uart_mem_cmd_initiator;

    localparam int RESP_TIMEOUT = 16;
    localparam int FRAME_GAP    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        cpu_enable;
    logic        mem_req;
    logic        mem_type;
    logic [8:0]  mem_addr;
    logic        mem_rw;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [41:0] mem_resp_data;
    logic        busy;

    uart_mem_cmd_initiator #(
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .FRAME_GAP    (FRAME_GAP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_byte        (rx_byte),
        .rx_valid       (rx_valid),
        .tx_byte        (tx_byte),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .cpu_enable     (cpu_enable),
        .mem_req        (mem_req),
        .mem_type       (mem_type),
        .mem_addr       (mem_addr),
        .mem_rw         (mem_rw),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        typ;
        logic [8:0]  addr;
        logic        rw;
        logic [31:0] wdata;
        logic        chk_wdata;
        int          len;
    } req_t;

    req_t       exp_req_q[$];
    logic [7:0] exp_tx_q[$];
    int         check_cnt = 0;
    int         fail_cnt  = 0;
    logic       bp_mode   = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick(1);
            n++;
        end
        check_val("wait_idle", busy, 0);
    endtask

    task automatic push_req(input logic typ, input logic [8:0] addr, input logic rw,
                            input logic [31:0] wdata, input logic chk_wdata, input int len);
        req_t r;
        r.typ = typ; r.addr = addr; r.rw = rw; r.wdata = wdata; r.chk_wdata = chk_wdata; r.len = len;
        exp_req_q.push_back(r);
    endtask

    task automatic push_reply6(input logic [41:0] resp);
        logic [47:0] r;
        r = {6'b0, resp};
        for (int i = 0; i < 6; i++)
            exp_tx_q.push_back(r[47 - 8*i -: 8]);
    endtask

    // Drives a read frame and answers it `delay` cycles after mem_req rises.
    task automatic do_read(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [41:0] resp, input int delay);
        send_byte(b0);
        send_byte(b1);
        check_val("rd_req_latency", mem_req, 1);
        tick(delay);
        mem_resp_valid = 1'b1;
        mem_resp_data  = resp;
        tick(1);
        mem_resp_valid = 1'b0;
        check_val("rd_tx_latency", tx_valid, 1);
        check_val("rd_req_fall", mem_req, 0);
    endtask

    // tx_ready pattern: always high, or in backpressure mode 5 low cycles then 1 high.
    initial begin
        int bp_cnt = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_mode) begin
                tx_ready = 1'b1;
                bp_cnt   = 0;
            end else if (bp_cnt == 5) begin
                tx_ready = 1'b1;
                bp_cnt   = 0;
            end else begin
                tx_ready = 1'b0;
                bp_cnt++;
            end
        end
    end

    // Monitors: memory request pulses and tx handshakes.
    req_t       cur_req;
    logic       req_active = 1'b0;
    logic       req_prev   = 1'b0;
    int         req_len    = 0;
    logic       tx_prev    = 1'b0;
    logic       hs_prev    = 1'b0;
    logic [7:0] byte_prev  = 8'h00;

    always @(negedge clk) begin
        logic hs;
        if (reset) begin
            req_active = 1'b0;
            req_prev   = 1'b0;
            req_len    = 0;
            tx_prev    = 1'b0;
            hs_prev    = 1'b0;
        end else begin
            if (mem_req && !req_prev) begin
                req_len = 1;
                if (exp_req_q.size() == 0) begin
                    check_val("req_unexpected", 1, 0);
                end else begin
                    cur_req    = exp_req_q.pop_front();
                    req_active = 1'b1;
                    $display("req type=%0d addr=0x%03h rw=%0d wdata=0x%08h", mem_type, mem_addr, mem_rw, mem_wdata);
                end
            end else if (mem_req) begin
                req_len++;
            end else if (req_prev && req_active) begin
                check_val("req_len", req_len, cur_req.len);
                req_active = 1'b0;
            end
            if (mem_req && req_active) begin
                check_val("req_type", mem_type, cur_req.typ);
                check_val("req_addr", mem_addr, cur_req.addr);
                check_val("req_rw", mem_rw, cur_req.rw);
                if (cur_req.chk_wdata)
                    check_val("req_wdata", mem_wdata, cur_req.wdata);
            end
            req_prev = mem_req;

            if (tx_prev && !hs_prev) begin
                check_val("tx_hold_valid", tx_valid, 1);
                check_val("tx_hold_byte", tx_byte, byte_prev);
            end
            hs = tx_valid && tx_ready;
            if (hs) begin
                if (exp_tx_q.size() == 0) begin
                    check_val("tx_unexpected", 1, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_tx_q.pop_front();
                    check_val("tx_byte", tx_byte, e);
                    $display("tx byte=0x%02h", tx_byte);
                end
            end
            tx_prev   = tx_valid;
            hs_prev   = hs;
            byte_prev = tx_byte;
        end
    end

    initial begin
        reset          = 1'b1;
        rx_byte        = 8'h00;
        rx_valid       = 1'b0;
        cpu_enable     = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        tick(3);
        check_val("rst_mem_req", mem_req, 0);
        check_val("rst_tx_valid", tx_valid, 0);
        check_val("rst_tx_byte", tx_byte, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        tick(2);

        // Write with CPU halted: one-cycle request, ack reply.
        push_req(1'b0, 9'h010, 1'b1, 32'hDEADBEEF, 1'b1, 1);
        exp_tx_q.push_back(8'hA5);
        send_byte(8'h80);
        send_byte(8'h10);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        check_val("wr_req_latency", mem_req, 1);
        tick(1);
        check_val("wr_req_one_cycle", mem_req, 0);
        wait_idle(50);

        // A response strobe while idle must be ignored.
        mem_resp_valid = 1'b1;
        mem_resp_data  = 42'h3FF_FFFFFFFF;
        tick(1);
        mem_resp_valid = 1'b0;
        check_val("idle_resp_ignored", busy, 0);
        tick(2);

        // Read answered two cycles after the request.
        push_req(1'b1, 9'h123, 1'b0, 32'h0, 1'b0, 3);
        push_reply6(42'h1_23_CAFEF00D);
        do_read(8'h41, 8'h23, 42'h1_23_CAFEF00D, 2);
        wait_idle(50);

        // Read with no response: request held RESP_TIMEOUT cycles, timeout reply.
        push_req(1'b0, 9'h005, 1'b0, 32'h0, 1'b0, RESP_TIMEOUT);
        exp_tx_q.push_back(8'hEE);
        send_byte(8'h00);
        send_byte(8'h05);
        check_val("to_req_latency", mem_req, 1);
        wait_idle(60);

        // Write while the CPU runs: no request, busy reply.
        cpu_enable = 1'b1;
        exp_tx_q.push_back(8'hEB);
        send_byte(8'h80);
        send_byte(8'h10);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check_val("busy_no_req", mem_req, 0);
        wait_idle(50);
        cpu_enable = 1'b0;
        tick(2);

        // Read reply under backpressure; a byte arriving mid-reply is dropped.
        bp_mode = 1'b1;
        push_req(1'b1, 9'h155, 1'b0, 32'h0, 1'b0, 4);
        push_reply6({1'b1, 9'h155, 32'hA1B2C3D4});
        do_read(8'h41, 8'h55, {1'b1, 9'h155, 32'hA1B2C3D4}, 3);
        tick(2);
        send_byte(8'h80);
        wait_idle(300);
        tick(2);

        // Reset in the middle of a backpressured reply.
        push_req(1'b1, 9'h0AB, 1'b0, 32'h0, 1'b0, 2);
        push_reply6({1'b0, 9'h0AB, 32'h55AA1234});
        do_read(8'h40, 8'hAB, {1'b0, 9'h0AB, 32'h55AA1234}, 1);
        tick(8);
        #2;
        reset = 1'b1;
        #1;
        check_val("midtx_rst_tx_valid", tx_valid, 0);
        check_val("midtx_rst_busy", busy, 0);
        check_val("midtx_rst_mem_req", mem_req, 0);
        exp_tx_q.delete();
        tick(2);
        reset   = 1'b0;
        bp_mode = 1'b0;
        tick(2);

        // Fresh write after reset to the top address of instruction memory.
        push_req(1'b1, 9'h1FF, 1'b1, 32'h01234567, 1'b1, 1);
        exp_tx_q.push_back(8'hA5);
        send_byte(8'hC1);
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'h45);
        send_byte(8'h67);
        check_val("wr2_req_latency", mem_req, 1);
        wait_idle(50);

`ifdef UART_MEM_FRAME_TIMEOUT_EN
        // A stalled partial frame is discarded after FRAME_GAP idle cycles.
        send_byte(8'h80);
        tick(FRAME_GAP - 1);
        check_val("gap_still_busy", busy, 1);
        tick(1);
        check_val("gap_discard", busy, 0);
        push_req(1'b0, 9'h007, 1'b0, 32'h0, 1'b0, RESP_TIMEOUT);
        exp_tx_q.push_back(8'hEE);
        send_byte(8'h00);
        send_byte(8'h07);
        check_val("gap_req_latency", mem_req, 1);
        wait_idle(60);
`endif

        tick(3);
        check_val("exp_req_left", exp_req_q.size(), 0);
        check_val("exp_tx_left", exp_tx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
